// File: rtl/pe_pkg.sv
// -----------------------------------------------------------------------------
// pe_pkg
// Shared definitions for the row-stationary PE and its row feeder:
//   - default word width and row lengths (filter, ifmap, psum)
//   - word_t: one signed data word
//   - feeder_state_e: states of the feeder's job sequencer
// -----------------------------------------------------------------------------
package pe_pkg;

  localparam int PE_INWIDTH = 16;
  localparam int PE_FIL_S   = 3;
  localparam int PE_DI_W    = 7;
  localparam int PE_DO_W    = PE_DI_W - PE_FIL_S + 1;

  typedef logic signed [PE_INWIDTH-1:0] word_t;

  typedef enum logic [1:0] {
    ST_LOAD,   // accepting the job frame
    ST_START,  // one-cycle PE start pulse
    ST_WAIT,   // waiting for the PE result
    ST_DRAIN   // streaming the psum row out
  } feeder_state_e;

endpackage

// File: rtl/pe_row_feeder.sv
// -----------------------------------------------------------------------------
// pe_row_feeder
// Deserialises one job frame (filter row, ifmap row, psum row) from the global
// buffer, presents the rows in parallel to one PE, pulses pe_start, captures
// the PE psum row on pe_done and serialises it back to the global buffer.
//
// Ports
//   clk, rst                    clock; asynchronous active-low reset
//   s_valid/s_ready/s_data/s_last  input word stream (frame of FIL_S+DI_W+DO_W)
//   pe_start                    one-cycle pulse: PE operands valid
//   pe_filter/pe_data/pe_psum   parallel rows to the PE (element i = word i)
//   pe_done/pe_result           PE result row, valid when pe_done=1
//   m_valid/m_ready/m_data/m_last  output psum stream (m_last on word DO_W-1)
//   err                         sticky framing error
// -----------------------------------------------------------------------------
module pe_row_feeder
  import pe_pkg::*;
#(
  parameter int INWIDTH = PE_INWIDTH,
  parameter int FIL_S   = PE_FIL_S,
  parameter int DI_W    = PE_DI_W,
  parameter int DO_W    = PE_DO_W
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            s_valid,
  output logic                            s_ready,
  input  logic [INWIDTH-1:0]              s_data,
  input  logic                            s_last,
  output logic                            pe_start,
  output logic [FIL_S-1:0][INWIDTH-1:0]   pe_filter,
  output logic [DI_W-1:0][INWIDTH-1:0]    pe_data,
  output logic [DO_W-1:0][INWIDTH-1:0]    pe_psum,
  input  logic                            pe_done,
  input  logic [DO_W-1:0][INWIDTH-1:0]    pe_result,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic [INWIDTH-1:0]              m_data,
  output logic                            m_last,
  output logic                            err
);

  localparam int N  = FIL_S + DI_W + DO_W;
  localparam int CW = $clog2(N + 1);
  localparam int KW = (DO_W > 1) ? $clog2(DO_W) : 1;

  feeder_state_e state, state_nxt;

  logic [CW-1:0]                  cnt;
  logic [KW-1:0]                  k;
  logic [DO_W-1:0][INWIDTH-1:0]   out_row;
  logic                           ready_en;   // holds s_ready low while in reset

  logic xfer, frame_end, frame_good, frame_bad, drain_last;

  assign xfer       = s_valid && s_ready;
  assign frame_end  = (cnt == CW'(N - 1));
  assign frame_good = xfer && s_last && frame_end;
  // Early s_last, or no s_last on the final slot, are both framing errors.
  assign frame_bad  = xfer && (s_last != frame_end);
  assign drain_last = (k == KW'(DO_W - 1));

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_LOAD;
    else      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    // NOTE: assigning the default first means every path drives state_nxt,
    // so no latch is inferred.
    state_nxt = state;
    unique case (state)
      ST_LOAD:  if (frame_good)            state_nxt = ST_START;
      ST_START:                            state_nxt = ST_WAIT;
      ST_WAIT:  if (pe_done)               state_nxt = ST_DRAIN;
      ST_DRAIN: if (m_ready && drain_last) state_nxt = ST_LOAD;
      default:                             state_nxt = ST_LOAD;
    endcase
  end

  // Datapath: frame counter, row registers, drain index, error flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the row registers are few and must read 0 out of reset, so they
      // sit on the async reset like the control flops.
      ready_en  <= 1'b0;
      cnt       <= '0;
      k         <= '0;
      err       <= 1'b0;
      pe_filter <= '0;
      pe_data   <= '0;
      pe_psum   <= '0;
      out_row   <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      ready_en <= 1'b1;
      unique case (state)
        ST_LOAD: begin
          if (xfer) begin
            for (int i = 0; i < FIL_S; i++)
              if (cnt == CW'(i)) pe_filter[i] <= s_data;
            for (int i = 0; i < DI_W; i++)
              if (cnt == CW'(FIL_S + i)) pe_data[i] <= s_data;
            for (int i = 0; i < DO_W; i++)
              if (cnt == CW'(FIL_S + DI_W + i)) pe_psum[i] <= s_data;
            if (frame_good || frame_bad) cnt <= '0;
            else                         cnt <= cnt + CW'(1);
            if (frame_bad) err <= 1'b1;
          end
        end
        ST_WAIT: begin
          k <= '0;
          if (pe_done) out_row <= pe_result;
        end
        ST_DRAIN: begin
          if (m_ready) k <= drain_last ? '0 : k + KW'(1);
        end
        default: ;
      endcase
    end
  end

  assign s_ready  = ready_en && (state == ST_LOAD);
  assign pe_start = (state == ST_START);
  assign m_valid  = (state == ST_DRAIN);
  assign m_data   = m_valid ? out_row[k] : '0;
  assign m_last   = m_valid && drain_last;

endmodule

// File: tb/tb_pe_row_feeder.sv
// -----------------------------------------------------------------------------
// tb_pe_row_feeder
// Self-checking bench for pe_row_feeder. The main process drives job frames
// and plays the PE; expected output words are queued when the PE result is
// driven and compared by the output monitor while m_valid is high.
// -----------------------------------------------------------------------------
module tb_pe_row_feeder;
  import pe_pkg::*;

  localparam int W  = PE_INWIDTH;
  localparam int FS = PE_FIL_S;
  localparam int DW = PE_DI_W;
  localparam int OW = PE_DO_W;
  localparam int N  = FS + DW + OW;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    s_valid, s_ready, s_last;
  logic [W-1:0]            s_data;
  logic                    pe_start, pe_done;
  logic [FS-1:0][W-1:0]    pe_filter;
  logic [DW-1:0][W-1:0]    pe_data;
  logic [OW-1:0][W-1:0]    pe_psum;
  logic [OW-1:0][W-1:0]    pe_result;
  logic                    m_valid, m_ready, m_last, err;
  logic [W-1:0]            m_data;

  always #5 clk = ~clk;

  pe_row_feeder dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_last    (s_last),
    .pe_start  (pe_start),
    .pe_filter (pe_filter),
    .pe_data   (pe_data),
    .pe_psum   (pe_psum),
    .pe_done   (pe_done),
    .pe_result (pe_result),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last),
    .err       (err)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct { logic [W-1:0] data; logic last; } exp_t;
  exp_t q[$];

  // Current frame contents (bench copy)
  int fil [FS];
  int dat [DW];
  int psm [OW];

  int  start_cnt  = 0;
  int  xfers      = 0;
  bit  ready_mode = 1'b0;   // 0: m_ready always 1; 1: pattern 1,0,0,1

  // Output monitor + m_ready driver
  initial begin : monitor
    int   phase;
    exp_t d;
    phase   = 0;
    m_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (ready_mode) m_ready = (phase % 4 == 0) || (phase % 4 == 3);
      else            m_ready = 1'b1;
      phase++;
      if (pe_start) start_cnt++;
      if (m_valid) begin
        if (q.size() == 0) check("m_valid_unexpected", m_valid, 1'b0);
        else begin
          check("m_data", m_data, q[0].data);
          check("m_last", m_last, q[0].last);
          if (m_ready) begin
            d = q.pop_front();
            xfers++;
          end
        end
      end
    end
  end

  function automatic logic [W-1:0] word_at(input int w);
    if (w < FS)           return W'(fil[w]);
    else if (w < FS + DW) return W'(dat[w - FS]);
    else                  return W'(psm[w - FS - DW]);
  endfunction

  function automatic logic [W-1:0] conv_out(input int j);
    int acc;
    acc = psm[j];
    for (int i = 0; i < FS; i++) acc += fil[i] * dat[j + i];
    return W'(acc);
  endfunction

  // Send nwords of the current frame; s_last on word last_idx (-1: none).
  task automatic send_frame(input int nwords, input int last_idx);
    int n;
    for (int w = 0; w < nwords; w++) begin
      s_valid = 1'b1;
      s_data  = word_at(w);
      s_last  = (w == last_idx);
      n = 0;
      while (!s_ready && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (n >= 100) begin
        check("s_ready_timeout", 1'b0, 1'b1);
        break;
      end
      @(negedge clk);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // Good frame: send, check pe_start one cycle after the last word.
  task automatic send_good(input string tag);
    send_frame(N, N - 1);
    check({tag, "_pe_start"}, pe_start, 1'b1);
  endtask

  // Act as the PE: return the convolution row ~3 cycles after pe_start.
  task automatic run_pe(input string tag);
    logic [OW-1:0][W-1:0] r;
    exp_t e;
    for (int j = 0; j < OW; j++) begin
      r[j]   = conv_out(j);
      e.data = r[j];
      e.last = (j == OW - 1);
      q.push_back(e);
    end
    repeat (2) @(negedge clk);
    pe_done   = 1'b1;
    pe_result = r;
    @(negedge clk);
    pe_done   = 1'b0;
    pe_result = {OW{W'($urandom)}};
    check({tag, "_m_valid_latency"}, m_valid, 1'b1);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((m_valid || q.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_drain_timeout"}, (n >= 200), 1'b0);
  endtask

  task automatic check_rows(input string tag);
    logic [FS-1:0][W-1:0] ef;
    logic [DW-1:0][W-1:0] ed;
    logic [OW-1:0][W-1:0] ep;
    for (int i = 0; i < FS; i++) ef[i] = W'(fil[i]);
    for (int i = 0; i < DW; i++) ed[i] = W'(dat[i]);
    for (int i = 0; i < OW; i++) ep[i] = W'(psm[i]);
    check({tag, "_pe_filter"}, pe_filter, ef);
    check({tag, "_pe_data"},   pe_data,   ed);
    check({tag, "_pe_psum"},   pe_psum,   ep);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int sc0, x0;
    rst       = 1'b0;
    s_valid   = 1'b0;
    s_data    = '0;
    s_last    = 1'b0;
    pe_done   = 1'b0;
    pe_result = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_s_ready",  s_ready,  1'b0);
    check("rst_pe_start", pe_start, 1'b0);
    check("rst_m_valid",  m_valid,  1'b0);
    check("rst_m_data",   m_data,   '0);
    check("rst_m_last",   m_last,   1'b0);
    check("rst_err",      err,      1'b0);
    check("rst_pe_data",  pe_data,  '0);
    #2 rst = 1'b1;
    @(negedge clk);
    check("post_rst_s_ready", s_ready, 1'b1);

    // Test 1: filter 1,2,3; data 1..7; psum 0
    fil = '{1, 2, 3};
    for (int i = 0; i < DW; i++) dat[i] = i + 1;
    psm = '{0, 0, 0, 0, 0};
    send_good("t1");
    check_rows("t1");
    @(negedge clk);
    check("t1_pe_start_one_cycle", pe_start, 1'b0);
    check("t1_s_ready_wait", s_ready, 1'b0);

    // Test 2: PE returns 14,20,26,32,38; m_ready high
    x0 = xfers;
    repeat (1) @(negedge clk);
    ready_mode = 1'b0;
    // run_pe waits two more cycles, so pe_done lands 3 cycles after start
    pe_done = 1'b0;
    begin
      logic [OW-1:0][W-1:0] r;
      exp_t e;
      for (int j = 0; j < OW; j++) begin
        r[j]   = conv_out(j);
        e.data = r[j];
        e.last = (j == OW - 1);
        q.push_back(e);
      end
      check("t2_model_first", r[0], W'(14));
      @(negedge clk);
      pe_done   = 1'b1;
      pe_result = r;
      @(negedge clk);
      pe_done   = 1'b0;
      check("t2_m_valid_latency", m_valid, 1'b1);
      repeat (OW) @(negedge clk);
      check("t2_final_word_by_u_plus_dow", m_valid, 1'b0);
      check("t2_queue_empty", q.size(), 0);
      check("t2_xfers", xfers - x0, OW);
      check("t2_s_ready_back", s_ready, 1'b1);
    end

    // Test 3: same job, m_ready toggling 1,0,0,1
    ready_mode = 1'b1;
    x0 = xfers;
    send_good("t3");
    run_pe("t3");
    wait_idle("t3");
    check("t3_xfers", xfers - x0, OW);
    ready_mode = 1'b0;

    // Test 4: s_last on word 9 -> err, no pe_start; then good frame
    fil = '{2, -1, 3};
    dat = '{5, 0, -2, 7, 1, 1, 4};
    psm = '{10, 20, 30, 40, 50};
    sc0 = start_cnt;
    send_frame(10, 9);
    repeat (3) @(negedge clk);
    check("t4_err_set", err, 1'b1);
    check("t4_no_start", start_cnt, sc0);
    send_good("t4");
    check_rows("t4");
    run_pe("t4");
    wait_idle("t4");
    check("t4_err_sticky", err, 1'b1);

    // Test 5: spurious pe_done during LOAD is ignored
    pe_done   = 1'b1;
    pe_result = {OW{W'($urandom)}};
    @(negedge clk);
    pe_done   = 1'b0;
    @(negedge clk);
    check("t5_no_drain", m_valid, 1'b0);
    check("t5_s_ready", s_ready, 1'b1);
    fil = '{-3, 1, 2};
    dat = '{9, -8, 7, -6, 5, -4, 3};
    psm = '{-1, 100, 0, 7, -50};
    send_good("t5");
    run_pe("t5");
    wait_idle("t5");

    // Test 6: reset during DRAIN after 2 words
    send_good("t6");
    run_pe("t6");
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("t6_m_valid_async", m_valid, 1'b0);
    check("t6_m_data_async",  m_data,  '0);
    check("t6_s_ready_rst",   s_ready, 1'b0);
    q.delete();
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    check("t6_s_ready_after", s_ready, 1'b1);
    check("t6_err_cleared",   err,     1'b0);
    sc0 = start_cnt;
    // Missing s_last on word N-1 is also a framing error
    send_frame(N, -1);
    repeat (2) @(negedge clk);
    check("t6_err_no_last", err, 1'b1);
    check("t6_no_start", start_cnt, sc0);
    x0 = xfers;
    send_good("t6b");
    check_rows("t6b");
    run_pe("t6b");
    wait_idle("t6b");
    check("t6b_xfers", xfers - x0, OW);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
